// File: rtl/dot_accum_pkg.sv
// Shared types and default sizing for the dot-product accumulator.
// Optional feature macro used by this block: DOT_ACCUM_SAT_EN.
package dot_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int PROD_W      = 12;
    localparam int DEF_MAX_LEN = 32;
    localparam int DEF_ACC_W   = 16;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/dot_accum_add.sv
// Accumulator adder with carry-out; saturates instead of wrapping when
// DOT_ACCUM_SAT_EN is defined.
module dot_accum_add
    import dot_accum_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] raw_s;

    assign raw_s = {1'b0, a} + {1'b0, b};
    assign carry = raw_s[ACC_W];

`ifdef DOT_ACCUM_SAT_EN
    // A saturated accumulator re-carries on any non-zero add, so it pins at max.
    assign sum = raw_s[ACC_W] ? {ACC_W{1'b1}} : raw_s[ACC_W-1:0];
`else
    assign sum = raw_s[ACC_W-1:0];
`endif

endmodule

// File: rtl/dot_accum_6x6.sv
// Group-wise accumulator of 12-bit products with a valid/ready result register.
// Build option DOT_ACCUM_SAT_EN selects saturating instead of wrapping sums.
module dot_accum_6x6
    import dot_accum_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_len,
    output logic              out_forced,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_t           state_r, state_nxt_s;
    logic [ACC_W-1:0] acc_r, acc_nxt_s, prod_ext_s, add_sum_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
    logic             add_carry_s;
    logic             ovf_r, ovf_nxt_s, forced_nxt_s, close_s;
    logic             rdy_en_r, in_ready_s, accept_s;
    logic             out_valid_r, out_forced_r, out_ovf_r;
    logic [ACC_W-1:0] out_sum_r;
    logic [CNT_W-1:0] out_len_r;

    assign prod_ext_s = ACC_W'(in_prod);
    assign cnt_inc_s  = cnt_r + ONE_CNT;
    assign accept_s   = in_valid & in_ready_s;

    dot_accum_add #(.ACC_W(ACC_W)) u_add (
        .a     (acc_r),
        .b     (prod_ext_s),
        .sum   (add_sum_s),
        .carry (add_carry_s)
    );

    // Ready decode: held low through reset, follows out_ready while a result is held.
    always_comb begin
        in_ready_s = 1'b0;
        if (!rdy_en_r) begin
            in_ready_s = 1'b0;
        end else if (state_r == ST_HOLD) begin
            in_ready_s = out_ready;
        end else begin
            in_ready_s = 1'b1;
        end
    end

    // Next-state, accumulator update and group-close decision.
    always_comb begin
        state_nxt_s  = state_r;
        acc_nxt_s    = acc_r;
        cnt_nxt_s    = cnt_r;
        ovf_nxt_s    = ovf_r;
        forced_nxt_s = 1'b0;
        close_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_HOLD: begin
                // In HOLD an accepted beat implies the held result leaves this cycle.
                if (accept_s) begin
                    acc_nxt_s = prod_ext_s;
                    cnt_nxt_s = ONE_CNT;
                    ovf_nxt_s = 1'b0;
                    if (in_last) begin
                        state_nxt_s = ST_HOLD;
                        close_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end else if ((state_r == ST_HOLD) && !out_ready) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s) begin
                    acc_nxt_s = add_sum_s;
                    cnt_nxt_s = cnt_inc_s;
                    ovf_nxt_s = ovf_r | add_carry_s;
                    if (in_last) begin
                        state_nxt_s = ST_HOLD;
                        close_s     = 1'b1;
                    end else if (cnt_inc_s == MAX_CNT) begin
                        state_nxt_s  = ST_HOLD;
                        close_s      = 1'b1;
                        forced_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            acc_r        <= {ACC_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            ovf_r        <= 1'b0;
            rdy_en_r     <= 1'b0;
            out_valid_r  <= 1'b0;
            out_sum_r    <= {ACC_W{1'b0}};
            out_len_r    <= {CNT_W{1'b0}};
            out_forced_r <= 1'b0;
            out_ovf_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ovf_r       <= ovf_nxt_s;
            rdy_en_r    <= 1'b1;
            out_valid_r <= (state_nxt_s == ST_HOLD);
            if (close_s) begin
                out_sum_r    <= acc_nxt_s;
                out_len_r    <= cnt_nxt_s;
                out_forced_r <= forced_nxt_s;
                out_ovf_r    <= ovf_nxt_s;
            end else begin
                out_sum_r    <= out_sum_r;
                out_len_r    <= out_len_r;
                out_forced_r <= out_forced_r;
                out_ovf_r    <= out_ovf_r;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_sum    = out_sum_r;
    assign out_len    = out_len_r;
    assign out_forced = out_forced_r;
    assign out_ovf    = out_ovf_r;

endmodule

// File: tb/tb_dot_accum_6x6.sv
// Self-checking bench for dot_accum_6x6: group table plus scoreboard, and
// hand sequences for reset, latency, HOLD back-pressure and mid-group reset.
module tb_dot_accum_6x6;

    localparam int MAX_LEN = 32;
    localparam int ACC_W   = 16;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [11:0]      in_prod;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_len;
    logic             out_forced;
    logic             out_ovf;

    dot_accum_6x6 #(.MAX_LEN(MAX_LEN), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_prod    (in_prod),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_len    (out_len),
        .out_forced (out_forced),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int len;
        bit forced;
        bit ovf;
    } res_t;

    // Group: beat 0 = v0, last beat = v2, middle beats = v1; n beats total.
    typedef struct {
        int v0;
        int v1;
        int v2;
        int n;
        bit last;
        res_t exp;
    } grp_t;

    res_t exp_q[$];
    grp_t tbl[8];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Presents one beat from posedge+1 and returns at posedge+1 after it is taken.
    task automatic send_beat(input int prod, input bit last);
        int waits;
        waits    = 0;
        in_valid = 1'b1;
        in_prod  = 12'(prod);
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            stall_cnt++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_accept: in_ready stuck at 0, required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Scoreboard: every result handshake pops and compares one expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got sum %0d, required no result", out_sum);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("res_sum", 32'(out_sum), 32'(e.sum));
                check("res_len", 32'(out_len), 32'(e.len));
                check("res_forced", 32'(out_forced), 32'(e.forced));
                check("res_ovf", 32'(out_ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        tbl[0] = '{3969, 3969, 1,    3, 1'b1, '{7939, 3, 1'b0, 1'b0}};
`ifdef DOT_ACCUM_SAT_EN
        tbl[1] = '{3969, 3969, 3969, 32, 1'b0, '{65535, 32, 1'b1, 1'b1}};
        tbl[6] = '{4095, 4095, 4095, 17, 1'b1, '{65535, 17, 1'b0, 1'b1}};
`else
        tbl[1] = '{3969, 3969, 3969, 32, 1'b0, '{61472, 32, 1'b1, 1'b1}};
        tbl[6] = '{4095, 4095, 4095, 17, 1'b1, '{4079, 17, 1'b0, 1'b1}};
`endif
        tbl[2] = '{25,  0,   0,   1,  1'b1, '{25,  1,  1'b0, 1'b0}};
        tbl[3] = '{10,  0,   20,  2,  1'b1, '{30,  2,  1'b0, 1'b0}};
        tbl[4] = '{30,  0,   0,   1,  1'b1, '{30,  1,  1'b0, 1'b0}};
        tbl[5] = '{1,   1,   1,   32, 1'b1, '{32,  32, 1'b0, 1'b0}};
        tbl[7] = '{100, 200, 300, 3,  1'b1, '{600, 3,  1'b0, 1'b0}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_prod   = 12'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset values and ready release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_len", 32'(out_len), 32'd0);
        check("rst_flags", 32'({out_forced, out_ovf}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rdy_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rdy_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: out_valid for exactly one cycle, one cycle after the closing beat.
        send_beat(3969, 1'b0);
        send_beat(3969, 1'b0);
        check("lat_early", 32'(out_valid), 32'd0);
        exp_q.push_back('{7939, 3, 1'b0, 1'b0});
        send_beat(1, 1'b1);
        @(negedge clk);
        check("lat_rise", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("lat_fall", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Table of groups, streamed back-to-back with out_ready held high.
        stall_cnt = 0;
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < tbl[g].n; i++) begin
                int v;
                bit l;
                v = (i == 0) ? tbl[g].v0 : ((i == tbl[g].n - 1) ? tbl[g].v2 : tbl[g].v1);
                l = tbl[g].last && (i == tbl[g].n - 1);
                if (i == tbl[g].n - 1) begin
                    exp_q.push_back(tbl[g].exp);
                end
                send_beat(v, l);
            end
        end
        repeat (3) @(negedge clk);
        check("b2b_no_stall", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;

        // HOLD back-pressure: beat 7 waits, then starts a group as 25 leaves.
        out_ready = 1'b0;
        exp_q.push_back('{25, 1, 1'b0, 1'b0});
        send_beat(25, 1'b1);
        in_valid = 1'b1;
        in_prod  = 12'd7;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_sum", 32'(out_sum), 32'd25);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back('{7, 1, 1'b0, 1'b0});
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("new_group_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        // Reset pulse mid-group with a beat presented in the reset cycle.
        send_beat(100, 1'b0);
        send_beat(100, 1'b0);
        in_valid = 1'b1;
        in_prod  = 12'd100;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_sum_clear", 32'(out_sum), 32'd0);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("midrst_no_valid", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back('{5, 1, 1'b0, 1'b0});
        send_beat(5, 1'b1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_accum_6x6.md
# dot_accum_6x6

Sequential dot-product accumulator placed directly downstream of the combinational 6x6 compressor-tree multiplier `onestepfull_6_6_aplusc`. It consumes one 12-bit unsigned product per accepted beat and sums a group of beats delimited by `in_last`, or closed automatically at `MAX_LEN` beats. It presents the group sum and beat count through a valid/ready output register. Together with the multiplier it forms the team's 6-bit MAC datapath.

## Interface
- `MAX_LEN`, default 32: maximum beats per group. Legal range 2..255.
- `ACC_W`, default 16: accumulator width. Legal range 12..24.
- `CNT_W`, default 8: beat-count width. Must satisfy 2^CNT_W > `MAX_LEN`.

- `clk`: input, 1 bit. The only clock; all state updates on its rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `in_valid`: input, 1 bit. A product beat is present.
- `in_prod`: input, 12 bits. Unsigned product; normally the multiplier output `c`.
- `in_last`: input, 1 bit. The beat closes the current group.
- `in_ready`: output, 1 bit. The block can accept a beat this cycle.
- `out_valid`: output, 1 bit. A group result is held.
- `out_ready`: input, 1 bit. Downstream takes the result.
- `out_sum`: output, `ACC_W` bits. Group sum.
- `out_len`: output, `CNT_W` bits. Number of beats in the group.
- `out_forced`: output, 1 bit. The group was closed by `MAX_LEN`, not by `in_last`.
- `out_ovf`: output, 1 bit. The sum exceeded 2^`ACC_W`-1 during the group.

## Operation
- States: IDLE, ACCUM, HOLD.
- A beat is accepted when `in_valid && in_ready`. `in_prod` is zero-extended to `ACC_W`.
- `in_ready`:
  - 1 in IDLE and ACCUM.
  - In HOLD, `in_ready` = `out_ready`, so a new group can start in the same cycle the result leaves.
- IDLE, on an accepted beat:
  - acc = prod; cnt = 1; ovf = 0.
  - If `in_last`, go to HOLD (single-beat group); otherwise go to ACCUM.
- ACCUM, on an accepted beat:
  - acc = acc + prod; cnt = cnt + 1; ovf is sticky-set on carry out of `ACC_W`.
  - If `in_last`, go to HOLD.
  - Else if the new cnt equals `MAX_LEN`, go to HOLD with forced = 1.
- ACCUM, with no accepted beat: hold all state. There is no timeout.
- HOLD, on `out_ready`:
  - Release the result.
  - If a beat is accepted in the same cycle, treat it as an IDLE first-beat and go to ACCUM or HOLD accordingly.
  - Otherwise go to IDLE.
- HOLD, without `out_ready`: all outputs stay stable.
- `in_last` arriving on the beat that also reaches `MAX_LEN` counts as a normal close: forced = 0.
- Output fields `out_sum`, `out_len`, `out_forced`, `out_ovf` are valid only while `out_valid`. Outside that, they hold their last value.

## Timing
- Reset value of every output is 0, including `in_ready`. Internal state resets to IDLE, acc = 0, cnt = 0, flags = 0.
- `in_ready` goes to 1 on the first cycle after `rst` deasserts.
- Latency: `out_valid` rises on the cycle after the closing beat is accepted.
- Throughput: one beat per clock, including across group boundaries when `out_ready` is held at 1.
- `rst` asserted mid-group or in HOLD:
  - The partial or held result is discarded at the next edge.
  - A beat presented in that same cycle is not accepted.
- All outputs are registered or decoded from state only. There is no combinational path from `in_*` to `out_*`.
- `in_ready` depends combinationally on `out_ready` in HOLD only.

## Configuration
- `DOT_ACCUM_SAT_EN` defined:
  - On overflow, acc saturates to 2^`ACC_W`-1 and stays there for the rest of the group.
  - `out_ovf` is sticky-set.
- `DOT_ACCUM_SAT_EN` undefined:
  - acc wraps modulo 2^`ACC_W`.
  - `out_ovf` still reports that at least one wrap occurred.

## Structure
- Shared package `dot_accum_pkg` holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - the product width constant `PROD_W` = 12;
  - the default `MAX_LEN`, `ACC_W`, `CNT_W`.
- One sub-module, `dot_accum_add`: combinational `ACC_W`-bit adder with carry-out. It contains the saturate/wrap selection under `DOT_ACCUM_SAT_EN`.
- The FSM, counter and output register live in the top module.

## Test plan
- Reset, then 3 beats: 3969, 3969, 1 with last on the third, `out_ready` = 1 → `out_sum` = 7939, `out_len` = 3, `out_forced` = 0, `out_ovf` = 0; `out_valid` for 1 cycle, starting 1 cycle after the third beat.
- 32 beats of 3969, no last, `ACC_W` = 16 → closes at beat 32 with `out_forced` = 1 and `out_ovf` = 1.
  - With `DOT_ACCUM_SAT_EN`: `out_sum` = 65535.
  - Without it: `out_sum` = 127008 mod 65536 = 61472.
- Single beat 25 with last → `out_sum` = 25, `out_len` = 1.
- `out_ready` = 0 for 5 cycles in HOLD while `in_valid` = 1 → `in_ready` = 0 and outputs stable. When `out_ready` rises, the result is released and the waiting beat 7 starts a new group in the same cycle.
- Back-to-back groups {10, 20 last} {30 last}, `out_ready` = 1 → results 30 (len 2) then 30 (len 1) with no idle cycle on `in_ready`.
- `rst` pulsed for 1 cycle after 2 beats of 100 → no `out_valid`; the next group {5 last} yields `out_sum` = 5, `out_len` = 1.
